// File: rtl/pipelined_cla_addsub_pkg.sv
// cla_pkg: operation encodings shared by the pipelined add/subtract unit and its users.
package cla_pkg;
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADDS = 2'b10,
    OP_SUBS = 2'b11
  } op_t;
endpackage

// File: rtl/pipelined_cla_addsub_if.sv
// pipelined_cla_addsub_if: operand/result handshake bundle of the pipelined add/subtract unit.
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 16
);
  import cla_pkg::*;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             v;
  logic             zero;
  logic             neg;
  modport master(
    output flush, in_valid, op, in0, in1, cin, out_ready,
    input  in_ready, out_valid, sum, cout, v, zero, neg
  );
  modport slave(
    input  flush, in_valid, op, in0, in1, cin, out_ready,
    output in_ready, out_valid, sum, cout, v, zero, neg
  );
endinterface

// File: rtl/pipelined_cla_addsub_cla_group.sv
// cla_group: one flat carry-lookahead group; every carry is a sum of generate/propagate products.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             c_in,
  output logic [GROUP-1:0] s,
  output logic             c_out,
  output logic             c_msb_in
);
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;
  logic             pp;
  logic             acc;
  assign p = a ^ b;
  assign g = a & b;
  always_comb begin
    c = '0;
    pp = 1'b1;
    acc = 1'b0;
    c[0] = c_in;
    for (int i = 0; i < GROUP; i++) begin
      pp = 1'b1;
      acc = g[i];
      for (int j = i - 1; j >= 0; j--) begin
        pp = pp & p[j+1];
        acc = acc | (pp & g[j]);
      end
      c[i+1] = acc | (pp & p[0] & c_in);
    end
  end
  assign s        = p ^ c[GROUP-1:0];
  assign c_out    = c[GROUP];
  assign c_msb_in = c[GROUP-1];
endmodule

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: STAGES-deep carry-lookahead add/sub with signed saturation and valid/ready flow.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_cla_addsub_if.slave bus
);
  localparam int NG  = WIDTH / GROUP;
  localparam int GPS = NG / STAGES;
  localparam int NR  = STAGES > 1 ? STAGES - 1 : 1;
  logic             en;
  logic [WIDTH-1:0] ai [STAGES];
  logic [WIDTH-1:0] bi [STAGES];
  logic [WIDTH-1:0] si [STAGES];
  logic [WIDTH-1:0] so [STAGES];
  logic             ci [STAGES];
  logic             vi [STAGES];
  op_t              oi [STAGES];
  logic [WIDTH-1:0] ra [NR];
  logic [WIDTH-1:0] rb [NR];
  logic [WIDTH-1:0] rs [NR];
  logic             rc [NR];
  logic             rv [NR];
  op_t              rop [NR];
  logic [WIDTH-1:0] gs;
  logic [NG-1:0]    gco;
  logic [NG-1:0]    gcm;
  logic             unused_gcm;
  logic             ov;
  logic             sat;
  logic [WIDTH-1:0] res;
  assign en           = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = en;
  // stage 0 sees the live operands with B already inverted for subtraction
  always_comb begin
    ai[0] = bus.in0;
    bi[0] = bus.op[0] ? ~bus.in1 : bus.in1;
    ci[0] = bus.op == OP_ADD ? bus.cin : bus.op[0];
    si[0] = '0;
    oi[0] = bus.op;
    vi[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      ai[k] = ra[k-1];
      bi[k] = rb[k-1];
      ci[k] = rc[k-1];
      si[k] = rs[k-1];
      oi[k] = rop[k-1];
      vi[k] = rv[k-1];
    end
  end
  for (genvar g = 0; g < NG; g++) begin : grp
    logic c_g;
    if (g % GPS == 0) begin : head
      assign c_g = ci[g/GPS];
    end else begin : tail
      assign c_g = gco[g-1];
    end
    cla_group #(.GROUP(GROUP)) u_grp (
      .a       (ai[g/GPS][g*GROUP +: GROUP]),
      .b       (bi[g/GPS][g*GROUP +: GROUP]),
      .c_in    (c_g),
      .s       (gs[g*GROUP +: GROUP]),
      .c_out   (gco[g]),
      .c_msb_in(gcm[g])
    );
  end
  // each stage overlays the group sums it resolves onto the partial sum it inherited
  always_comb begin
    for (int k = 0; k < STAGES; k++) so[k] = si[k];
    for (int g = 0; g < NG; g++) so[g/GPS][g*GROUP +: GROUP] = gs[g*GROUP +: GROUP];
  end
  assign unused_gcm = ^gcm;
  assign ov  = gco[NG-1] ^ gcm[NG-1];
  assign sat = oi[STAGES-1][1] & ov;
  assign res = !sat ? so[STAGES-1] :
               ai[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NR; k++) rv[k] <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.v         <= 1'b0;
      bus.zero      <= 1'b0;
      bus.neg       <= 1'b0;
    end else if (bus.flush) begin
      for (int k = 0; k < NR; k++) rv[k] <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.v         <= 1'b0;
      bus.zero      <= 1'b0;
      bus.neg       <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES - 1; k++) rv[k] <= vi[k];
      bus.out_valid <= vi[STAGES-1];
      bus.sum       <= res;
      bus.cout      <= gco[NG-1];
      bus.v         <= ov;
      bus.zero      <= res == '0;
      bus.neg       <= res[WIDTH-1];
    end
  end
  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        ra[k]  <= ai[k];
        rb[k]  <= bi[k];
        rs[k]  <= so[k];
        rc[k]  <= gco[(k+1)*GPS-1];
        rop[k] <= oi[k];
      end
    end
  end
endmodule
